// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, character
// length limits and FIFO level sizing helpers.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int MIN_DATA_BITS = 5;

    // A level counter must hold DEPTH itself, hence the extra bit.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [3:0] clamp_bits(input logic [3:0] req, input int max_bits);
        logic [3:0] res;
        res = req;
        if (int'(req) < MIN_DATA_BITS) begin
            res = 4'(MIN_DATA_BITS);
        end else if (int'(req) > max_bits) begin
            res = 4'(max_bits);
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead FIFO; the head entry is visible on rdata_o whenever the
// FIFO is non-empty and reads as zero otherwise.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign level_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees the head slot in the same cycle, so a push into a full FIFO
    // is accepted when accompanied by a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: oversampled deframing FSM with optional parity, feeding a
// show-ahead FIFO, with sticky error flags and a registered level interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int OVERSAMPLE    = 16
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic                                rx_sample_pulse,
    input  logic                                RX,
    input  logic [3:0]                          data_bits,
    input  logic                                parity_en,
    input  logic                                parity_odd0_even1,
    input  logic [lvl_width(FIFO_DEPTH)-1:0]    int_thresh,
    input  logic                                rd_en,
    input  logic                                err_clr,
    output logic [MAX_DATA_BITS-1:0]            rx_data,
    output logic                                rx_ready,
    output logic [lvl_width(FIFO_DEPTH)-1:0]    fifo_level,
    output logic                                parity_err,
    output logic                                framing_err,
    output logic                                overflow,
    output logic                                rx_int
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    logic                     rx_s1_q, rx_s2_q;
    rx_state_e                state_q, state_d;
    logic [TW-1:0]            tick_q, tick_d;
    logic [3:0]               bit_q, bit_d;
    logic [3:0]               nbits_q, nbits_d;
    logic                     par_en_q, par_en_d;
    logic                     par_even_q, par_even_d;
    logic                     par_bad_q, par_bad_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     perr_q, ferr_q, ovf_q, int_q;

    logic                     push;
    logic                     set_perr, set_ferr, set_ovf;
    logic [MAX_DATA_BITS-1:0] push_data;
    logic                     fifo_full, fifo_empty;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            nbits_q    <= 4'(MIN_DATA_BITS);
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            par_bad_q  <= 1'b0;
            shift_q    <= '0;
        end else begin
            rx_s1_q    <= RX;
            rx_s2_q    <= rx_s1_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_even_q <= par_even_d;
            par_bad_q  <= par_bad_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_even_d = par_even_q;
        par_bad_d  = par_bad_q;
        shift_d    = shift_q;
        if (rx_sample_pulse) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s2_q) begin
                        state_d    = ST_START;
                        tick_d     = '0;
                        bit_d      = '0;
                        shift_d    = '0;
                        par_bad_d  = 1'b0;
                        nbits_d    = clamp_bits(data_bits, MAX_DATA_BITS);
                        par_en_d   = parity_en;
                        par_even_d = parity_odd0_even1;
                    end
                end
                ST_START: begin
                    if (tick_q == MID_TICK) begin
                        state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_q == LAST_TICK) begin
                        // Bits enter at the top and are right-aligned when pushed.
                        shift_d = {rx_s2_q, shift_q[MAX_DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == nbits_q - 4'd1) begin
                            state_d = par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                ST_PARITY: begin
                    if (tick_q == LAST_TICK) begin
                        par_bad_d = (^shift_q) ^ rx_s2_q ^ ~par_even_q;
                        state_d   = ST_STOP;
                        tick_d    = '0;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    if (tick_q == LAST_TICK) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        push      = (state_q == ST_STOP) && rx_sample_pulse && (tick_q == LAST_TICK);
        push_data = shift_q >> (4'(MAX_DATA_BITS) - nbits_q);
        set_ferr  = push & ~rx_s2_q;
        set_perr  = push & par_bad_q;
        set_ovf   = push & fifo_full & ~rd_en;
    end

    uart_sync_fifo #(
        .WIDTH (MAX_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (rd_en),
        .rdata_o (rx_data),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
            int_q  <= 1'b0;
        end else begin
            perr_q <= set_perr | (perr_q & ~err_clr);
            ferr_q <= set_ferr | (ferr_q & ~err_clr);
            ovf_q  <= set_ovf  | (ovf_q  & ~err_clr);
            int_q  <= ((fifo_level >= int_thresh) && (int_thresh != '0)) | perr_q | ferr_q | ovf_q;
        end
    end

    assign rx_ready    = ~fifo_empty;
    assign parity_err  = perr_q;
    assign framing_err = ferr_q;
    assign overflow    = ovf_q;
    assign rx_int      = int_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit by bit at 16 cycles
// per bit and the FIFO, flags and interrupt are checked against fixed values.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse;
    logic       rx;
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_even;
    logic [3:0] int_thresh;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [3:0] fifo_level;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;
    logic       rx_int;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .MAX_DATA_BITS (8),
        .FIFO_DEPTH    (8),
        .OVERSAMPLE    (16)
    ) dut (
        .ACLK              (clk),
        .ARESETn           (rst_n),
        .rx_sample_pulse   (pulse),
        .RX                (rx),
        .data_bits         (data_bits),
        .parity_en         (parity_en),
        .parity_odd0_even1 (parity_even),
        .int_thresh        (int_thresh),
        .rd_en             (rd_en),
        .err_clr           (err_clr),
        .rx_data           (rx_data),
        .rx_ready          (rx_ready),
        .fifo_level        (fifo_level),
        .parity_err        (parity_err),
        .framing_err       (framing_err),
        .overflow          (overflow),
        .rx_int            (rx_int)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode 1: check rx_ready latency around the push; mode 2: pop coincident with the push
    task automatic send_frame(input logic [8:0] data, input int nbits, input logic [3:0] cfg_bits,
                              input logic pen, input logic peven, input logic pbit,
                              input logic stop, input int mode);
        data_bits   = cfg_bits;
        parity_en   = pen;
        parity_even = peven;
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            repeat (16) @(posedge clk);
            #1 rx = data[i];
        end
        if (pen) begin
            repeat (16) @(posedge clk);
            #1 rx = pbit;
        end
        repeat (16) @(posedge clk);
        #1 rx = stop;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (mode == 1 && c == 10) check("ready_before_push", rx_ready, 0);
            if (mode == 1 && c == 11) check("ready_after_push", rx_ready, 1);
            if (mode == 2 && c == 10) rd_en = 1'b1;
            if (mode == 2 && c == 11) rd_en = 1'b0;
        end
        rx = 1'b1;
        $display("frame data=0x%0h bits=%0d parity_en=%0d stop=%0d level=%0d", data, nbits, pen, stop, fifo_level);
    endtask

    task automatic pop_one();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_head;
        rst_n = 1'b0; pulse = 1'b1; rx = 1'b1; data_bits = 4'd8; parity_en = 1'b0;
        parity_even = 1'b0; int_thresh = 4'd0; rd_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_level", fifo_level, 0);
        check("rst_errs", {parity_err, framing_err, overflow}, 0);
        check("rst_int", rx_int, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 8N1 0xA5
        send_frame(9'h0A5, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_level", fifo_level, 1);
        check("a5_errs", {parity_err, framing_err, overflow}, 0);
        pop_one();
        check("a5_popped_ready", rx_ready, 0);
        check("a5_popped_level", fifo_level, 0);

        // 7E1 0x41 with wrong parity bit (correct even parity would be 0)
        send_frame(9'h041, 7, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        check("p41_data", rx_data, 8'h41);
        check("p41_parity_err", parity_err, 1);
        check("p41_int", rx_int, 1);
        clear_errs();
        check("p41_cleared", parity_err, 0);
        @(posedge clk); #1;
        check("p41_int_drop", rx_int, 0);
        pop_one();

        // 5-bit 0x1F (length 3 clamps to 5), then 8-bit 0x3C (length 15 clamps to 8) with bad stop
        send_frame(9'h01F, 5, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_frame(9'h03C, 8, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (8) @(posedge clk);
        #1;
        check("fr_level", fifo_level, 2);
        check("fr_head0", rx_data, 8'h1F);
        check("fr_framing", framing_err, 1);
        check("fr_parity", parity_err, 0);
        pop_one();
        check("fr_head1", rx_data, 8'h3C);
        pop_one();
        check("fr_empty", rx_ready, 0);
        clear_errs();
        check("fr_cleared", framing_err, 0);

        // 9 frames without popping into an 8-entry FIFO
        for (int i = 0; i < 9; i++) begin
            send_frame(9'(8'h10 + i), 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        end
        check("ovf_level", fifo_level, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head", rx_data, 8'h10);
        clear_errs();
        check("ovf_cleared", overflow, 0);
        send_frame(9'h099, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        check("pp_level", fifo_level, 8);
        check("pp_no_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            exp_head = (i < 7) ? 8'(8'h11 + i) : 8'h99;
            check($sformatf("drain_%0d", i), rx_data, exp_head);
            pop_one();
        end
        check("drain_empty", rx_ready, 0);
        check("drain_level", fifo_level, 0);

        // 4-cycle low glitch in idle
        @(posedge clk); #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        $display("glitch level=%0d ready=%0d", fifo_level, rx_ready);
        check("glitch_ready", rx_ready, 0);
        check("glitch_level", fifo_level, 0);

        // Level interrupt at threshold 3
        int_thresh = 4'd3;
        send_frame(9'h001, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_frame(9'h002, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("int_below", rx_int, 0);
        check("int_level2", fifo_level, 2);
        send_frame(9'h003, 8, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        check("int_level3", fifo_level, 3);
        check("int_at_thresh", rx_int, 1);
        check("int_head", rx_data, 8'h01);

        // Reset in the middle of a frame
        @(posedge clk); #1 rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_ready", rx_ready, 0);
        check("mrst_level", fifo_level, 0);
        check("mrst_data", rx_data, 0);
        check("mrst_int", rx_int, 0);
        check("mrst_errs", {parity_err, framing_err, overflow}, 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("post_rst_level", fifo_level, 0);
        check("post_rst_ready", rx_ready, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receive path for the uart subsystem.
- Oversamples RX using the rx_sample_pulse enable from baud_clk_gen, deframes each character and pushes it into an internal show-ahead FIFO.
- Supports a runtime-configurable data length, optional parity, sticky error flags and a level-threshold interrupt.
- Register logic reads rx_data and pops with rd_en.

Parameters:
MAX_DATA_BITS, 8, widest character supported (5..9); width of rx_data.
FIFO_DEPTH, 8, receive FIFO entries (power of two, >=2).
OVERSAMPLE, 16, rx_sample_pulse ticks per bit (even, >=4).

Ports:
ACLK  in  1  clock.
ARESETn  in  1  asynchronous active-low reset.
rx_sample_pulse  in  1  oversample tick enable.
RX  in  1  serial input, idle high, asynchronous.
data_bits  in  4  character length 5..MAX_DATA_BITS.
parity_en  in  1  parity bit present.
parity_odd0_even1  in  1  parity sense.
int_thresh  in  log2(FIFO_DEPTH)+1  FIFO level that raises rx_int.
rd_en  in  1  pop head entry.
err_clr  in  1  clear sticky errors.
rx_data  out  MAX_DATA_BITS  FIFO head, zero-extended.
rx_ready  out  1  FIFO not empty.
fifo_level  out  log2(FIFO_DEPTH)+1  entries held.
parity_err  out  1  sticky.
framing_err  out  1  sticky.
overflow  out  1  sticky.
rx_int  out  1  level interrupt.

Behaviour:
Reset values:
- All outputs are 0; FIFO is empty.
- Synchroniser flops reset to 1; FSM resets to IDLE.

Input synchronisation:
- RX passes through a 2-flop synchroniser, so there is 2 cycles of latency before the FSM sees it.

Tick and bit counters:
- All FSM activity advances only on cycles with rx_sample_pulse=1.
- tick_cnt counts 0..OVERSAMPLE-1; bit_cnt counts data bits.

FSM states:
- IDLE: synchronised RX=0 on a tick -> START, tick_cnt=0.
  - data_bits, parity_en and parity_odd0_even1 are latched here and held for the whole frame.
  - data_bits <5 is treated as 5; data_bits >MAX_DATA_BITS is treated as MAX_DATA_BITS.
- START: at tick_cnt=OVERSAMPLE/2-1 (mid-bit):
  - RX=1 -> IDLE (glitch rejected, nothing pushed).
  - RX=0 -> DATA, tick_cnt=0.
- DATA: sample at tick_cnt=OVERSAMPLE-1 (mid of each bit), shifting LSB first.
  - After the latched count of bits -> PARITY if enabled, else STOP.
- PARITY: sample the parity bit, then compute the error.
  - Even mode: error if XOR(data, parity bit)=1.
  - Odd mode: error if XOR(data, parity bit)=0.
  - Then -> STOP.
- STOP: sample at mid-bit.
  - RX=0 sets framing_err; the character is still pushed.
  - Parity error sets parity_err at the same cycle as the push.
  - -> IDLE immediately, so back-to-back frames are accepted with a single stop bit.

FIFO:
- Write and pop pointers each carry one extra wrap bit; fifo_level = wptr - rptr.
- rx_data is the entry at rptr, show-ahead. It is valid while rx_ready=1; unused upper bits are 0.
- Push happens on the cycle the stop bit is sampled. Character-to-rx_ready latency is 1 cycle after that push cycle.
- Pop while empty is ignored; no pointer change.
- Push while full with no pop: the new character is dropped and overflow is set.
- Push and pop in the same cycle: both are performed, including when full. No overflow; the level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Sticky errors:
- Each sticky flag is cleared by err_clr.
- If a set event and err_clr occur in the same cycle, set wins.

Interrupt:
- rx_int = (fifo_level >= int_thresh && int_thresh != 0) | parity_err | framing_err | overflow, registered.

Reset mid-frame:
- The frame is abandoned and FIFO contents are lost.
- Only ARESETn resets state; there is no soft flush.

Decomposition:
- Shared uart defines/package holds:
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - the MIN_DATA_BITS=5 constant;
  - the FIFO level width macro.
- One sub-module: uart_sync_fifo, a generic show-ahead FIFO with push, pop, level and full/empty, parameterised on WIDTH and DEPTH.
- The FSM, synchroniser, error flags and interrupt stay in uart_rx_fifo.

Test Plan:
All scenarios use rx_sample_pulse=1 every cycle and OVERSAMPLE=16, so 1 bit = 16 cycles.
- 8N1 0xA5: rx_ready rises 1 cycle after the stop mid-sample; rx_data=0x0A5; fifo_level=1; no errors. rd_en -> rx_ready=0.
- 7E1 0x41 sent with a wrong parity bit: rx_data=0x41; parity_err=1; rx_int=1. err_clr -> parity_err=0.
- 5-bit frame 0x1F, then an 8-bit frame whose stop bit is driven 0: entries are 0x1F then that byte; framing_err=1.
- 9 frames with no pops (FIFO_DEPTH=8): fifo_level=8, overflow=1, head = first byte. Then rd_en coincident with a 10th push: level stays 8 and overflow is not set again after an err_clr.
- 4-cycle low glitch on RX in IDLE: returns to IDLE; no push; rx_ready stays 0.
- Set int_thresh=3 and push 0x01, 0x02, 0x03: rx_int goes 0 -> 1 after the third push. Assert ARESETn low mid-frame: all outputs 0, level 0.
